// File: rtl/axis_video_framer.sv
// AXI4-Stream video framer: tags each accepted beat with start-of-frame (tuser) and
// end-of-line (tlast) from beat/line counters, and forwards it through a fully registered skid buffer.
module axis_video_framer #(
   parameter int P_AXIS_DATA_WIDTH = 64,
   parameter int P_LINE_BEATS      = 160,
   parameter int P_FRAME_LINES     = 480
) (
   input  logic                         i_axis_clk,
   input  logic                         i_axis_rstn,
   input  logic                         i_ena,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic [P_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [P_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                         m_axis_tuser,
   output logic                         m_axis_tlast,
   output logic [15:0]                  o_frame_cnt
);

   localparam int BW = $clog2(P_LINE_BEATS);
   localparam int LW = $clog2(P_FRAME_LINES);
   localparam logic [BW-1:0] LAST_BEAT = BW'(P_LINE_BEATS - 1);
   localparam logic [LW-1:0] LAST_LINE = LW'(P_FRAME_LINES - 1);

   logic [BW-1:0]                beat_q, beat_d;
   logic [LW-1:0]                line_q, line_d;
   logic [15:0]                  frame_cnt_q, frame_cnt_d;
   logic                         rdy_q, rdy_d;
   logic                         out_valid_q, out_valid_d;
   logic [P_AXIS_DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                         out_user_q, out_user_d;
   logic                         out_last_q, out_last_d;
   logic                         skid_valid_q, skid_valid_d;
   logic [P_AXIS_DATA_WIDTH-1:0] skid_data_q, skid_data_d;
   logic                         skid_user_q, skid_user_d;
   logic                         skid_last_q, skid_last_d;

   logic accept_s;
   logic out_free_s;
   logic tag_user_s;
   logic tag_last_s;

   // rdy_q mirrors "skid empty" but stays low until the first edge after reset release
   assign s_axis_tready = rdy_q & i_ena;
   assign accept_s      = s_axis_tvalid & s_axis_tready;
   assign out_free_s    = ~out_valid_q | m_axis_tready;
   assign tag_user_s    = (beat_q == '0) && (line_q == '0);
   assign tag_last_s    = (beat_q == LAST_BEAT);

   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tuser  = out_user_q;
   assign m_axis_tlast  = out_last_q;
   assign o_frame_cnt   = frame_cnt_q;

   // Beat/line/frame position tracking; disabling framing rearms at frame start
   always_comb begin
      beat_d      = beat_q;
      line_d      = line_q;
      frame_cnt_d = frame_cnt_q;
      if (!i_ena) begin
         beat_d = '0;
         line_d = '0;
      end else if (accept_s) begin
         if (tag_last_s) begin
            beat_d = '0;
            if (line_q == LAST_LINE) begin
               line_d      = '0;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
               line_d = line_q + LW'(1);
            end
         end else begin
            beat_d = beat_q + BW'(1);
         end
      end else begin
         beat_d = beat_q;
      end
   end

   // Skid buffer next state; an accepted beat never meets a full skid since ready tracks it
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_user_d   = out_user_q;
      out_last_d   = out_last_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_user_d  = skid_user_q;
      skid_last_d  = skid_last_q;
      if (out_free_s && skid_valid_q) begin
         out_valid_d  = 1'b1;
         out_data_d   = skid_data_q;
         out_user_d   = skid_user_q;
         out_last_d   = skid_last_q;
         skid_valid_d = 1'b0;
      end else if (out_free_s && accept_s) begin
         out_valid_d = 1'b1;
         out_data_d  = s_axis_tdata;
         out_user_d  = tag_user_s;
         out_last_d  = tag_last_s;
      end else if (out_free_s) begin
         out_valid_d = 1'b0;
      end else if (accept_s) begin
         skid_valid_d = 1'b1;
         skid_data_d  = s_axis_tdata;
         skid_user_d  = tag_user_s;
         skid_last_d  = tag_last_s;
      end else begin
         skid_valid_d = skid_valid_q;
      end
      rdy_d = ~skid_valid_d;
   end

   // State registers
   always_ff @(posedge i_axis_clk or negedge i_axis_rstn) begin
      if (!i_axis_rstn) begin
         beat_q       <= '0;
         line_q       <= '0;
         frame_cnt_q  <= 16'd0;
         rdy_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_user_q   <= 1'b0;
         out_last_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_user_q  <= 1'b0;
         skid_last_q  <= 1'b0;
      end else begin
         beat_q       <= beat_d;
         line_q       <= line_d;
         frame_cnt_q  <= frame_cnt_d;
         rdy_q        <= rdy_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_user_q   <= out_user_d;
         out_last_q   <= out_last_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_user_q  <= skid_user_d;
         skid_last_q  <= skid_last_d;
      end
   end

endmodule

// File: tb/tb_axis_video_framer.sv
// Randomized bench for axis_video_framer (4 beats/line, 3 lines/frame) against a
// position-in-frame reference model with an expected-beat queue.
module tb_axis_video_framer;

   localparam int DW = 32;
   localparam int LB = 4;
   localparam int FL = 3;
   localparam int FB = LB * FL;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b0;
   logic          s_tvalid = 1'b0;
   logic          m_tready = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tready;
   logic          m_tvalid;
   logic          m_tuser;
   logic          m_tlast;
   logic [DW-1:0] m_tdata;
   logic [15:0]   frame_cnt;

   axis_video_framer #(
      .P_AXIS_DATA_WIDTH (DW),
      .P_LINE_BEATS      (LB),
      .P_FRAME_LINES     (FL)
   ) dut (
      .i_axis_clk    (clk),
      .i_axis_rstn   (rst_n),
      .i_ena         (ena),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tuser  (m_tuser),
      .m_axis_tlast  (m_tlast),
      .o_frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   int            n_chk = 0;
   int            n_pass = 0;
   logic [DW+1:0] exp_q[$];
   int            pos = 0;
   logic [15:0]   mdl_frames = 16'd0;
   logic          in_acc;
   logic          out_acc;
   logic [DW-1:0] nxt = 1;
   bit            lat_chk = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // One clock: sample handshakes, update model at the edge, check at the next falling edge.
   task automatic step();
      logic          held;
      logic [DW+1:0] pre_out;
      #1;
      in_acc  = s_tvalid & s_tready;
      out_acc = m_tvalid & m_tready;
      held    = m_tvalid & ~m_tready;
      pre_out = {m_tdata, m_tuser, m_tlast};
      @(posedge clk);
      if (in_acc) begin
         exp_q.push_back({s_tdata, pos == 0, (pos % LB) == LB - 1});
         pos++;
         if (pos == FB) begin
            pos = 0;
            mdl_frames++;
         end
      end
      if (!ena) pos = 0;
      @(negedge clk);
      if (out_acc) begin
         if (exp_q.size() == 0) chk("spurious_beat_q_size", 64'(exp_q.size()), 64'd1);
         else chk("beat", 64'(pre_out), 64'(exp_q.pop_front()));
      end
      if (held) chk("hold_stable", 64'({m_tdata, m_tuser, m_tlast}), 64'(pre_out));
      if (lat_chk && in_acc) chk("latency", 64'({m_tvalid, m_tdata}), 64'({1'b1, s_tdata}));
      chk("frame_cnt", 64'(frame_cnt), 64'(mdl_frames));
   endtask

   task automatic send_beats(input int n, input int pv, input int pr, input int budget);
      int sent = 0;
      int cyc = 0;
      while (sent < n && cyc < budget) begin
         s_tvalid = ($urandom_range(99) < pv);
         m_tready = ($urandom_range(99) < pr);
         s_tdata  = nxt;
         step();
         if (in_acc) begin
            nxt++;
            sent++;
         end
         cyc++;
      end
      s_tvalid = 1'b0;
      if (sent < n) chk("send_timeout", 64'(sent), 64'(n));
   endtask

   task automatic drain(input int budget);
      int cyc = 0;
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      while ((exp_q.size() != 0 || m_tvalid) && cyc < budget) begin
         step();
         cyc++;
      end
      chk("drain_q_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_tvalid", 64'(m_tvalid), 64'd0);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 chk("rst_async_outs", 64'({s_tready, m_tvalid, m_tuser, m_tlast, m_tdata, frame_cnt}), 64'd0);
      exp_q.delete();
      pos        = 0;
      mdl_frames = 16'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst_release_tready", 64'(s_tready), 64'd0);
   endtask

   initial begin
      // Reset state and release
      #1 chk("rst_outs", 64'({s_tready, m_tvalid, m_tuser, m_tlast, m_tdata, frame_cnt}), 64'd0);
      repeat (3) @(negedge clk);
      ena   = 1'b1;
      rst_n = 1'b1;
      #1 chk("rst_release_tready", 64'(s_tready), 64'd0);

      // Streaming: 24 beats, two full frames, single-cycle latency
      lat_chk = 1'b1;
      send_beats(24, 100, 100, 100);
      lat_chk = 1'b0;
      drain(20);
      chk("frames_stream", 64'(frame_cnt), 64'd2);

      // Backpressure mid-line
      send_beats(2, 100, 100, 20);
      for (int i = 0; i < 5; i++) begin
         m_tready = 1'b0;
         s_tvalid = 1'b1;
         s_tdata  = nxt;
         step();
         if (in_acc) nxt++;
         chk("bp_tready_low", 64'(s_tready), 64'd0);
      end
      send_beats(10, 100, 100, 50);
      drain(20);

      // Random valid/ready over 1200 beats from a fresh reset
      do_reset();
      send_beats(1200, 60, 60, 20000);
      drain(20);
      chk("frames_random", 64'(frame_cnt), 64'd100);

      // Enable drop after 6 beats, then re-enable
      send_beats(6, 100, 50, 200);
      ena = 1'b0;
      for (int i = 0; i < 6; i++) begin
         m_tready = 1'b1;
         s_tvalid = 1'b1;
         s_tdata  = nxt;
         step();
         chk("ena_low_tready", 64'(s_tready), 64'd0);
      end
      chk("ena_drained_q", 64'(exp_q.size()), 64'd0);
      chk("ena_drained_tvalid", 64'(m_tvalid), 64'd0);
      ena = 1'b1;
      send_beats(12, 80, 70, 200);
      drain(20);

      // Reset while the skid holds a beat
      send_beats(2, 100, 0, 20);
      chk("skid_full_tready", 64'(s_tready), 64'd0);
      do_reset();
      send_beats(12, 90, 90, 200);
      drain(20);

      // Frame counter wrap from a forced 0xFFFF
      do_reset();
      force dut.frame_cnt_q = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.frame_cnt_q;
      mdl_frames = 16'hFFFF;
      #1 chk("preset_ffff", 64'(frame_cnt), 64'hFFFF);
      send_beats(12, 100, 100, 50);
      drain(20);
      chk("frames_wrap", 64'(frame_cnt), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
